// File: rtl/game_pkg.sv
// Shared game definitions: state encodings driven by the game FSM and the
// screen constants also used by the VGA renderer.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } game_state_e;

  localparam int SCREEN_WRAP_X  = 896;
  localparam int SCREEN_SPAWN_Y = 260;

  // Spawn x of channel ch: staggered by spacing and folded back into 0..wrap.
  function automatic int spawn_x(input int spawn, input int spacing,
                                 input int wrap, input int ch);
    return (spawn + ch * spacing) % (wrap + 1);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Movement-rate divider: counts 0..DIV-1 while running and registers a
// one-cycle tick for the cycle after the terminal count. Holding run low
// freezes the phase; clear restarts it from zero.
module tick_divider #(
  parameter int DIV = 1048576
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q, count_d;
  logic          tick_q, tick_d;

  // Next count and tick strobe; clear has priority over run.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      if (count_q == LAST) begin
        count_d = '0;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // Counter and tick flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/sprite_scroller.sv
// Multi-channel sprite scroller: moves NUM_CH sprites right-to-left once per
// movement tick, wraps each one back to WRAP_X with a one-cycle wrap pulse,
// and optionally bobs each sprite vertically as a triangle wave about SPAWN_Y.
module sprite_scroller
  import game_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int DIV       = 1048576,
  parameter int STEP_X    = 2,
  parameter int SPAWN_X   = 800,
  parameter int SPACING_X = 320,
  parameter int SPAWN_Y   = SCREEN_SPAWN_Y,
  parameter int WRAP_X    = SCREEN_WRAP_X,
  parameter int BOB_AMP   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            state,
  input  logic [1:0]            speed_sel,
  input  logic [NUM_CH-1:0]     bob_en,
  output logic [NUM_CH*X_W-1:0] pos_x,
  output logic [NUM_CH*Y_W-1:0] pos_y,
  output logic [NUM_CH-1:0]     wrap_pulse,
  output logic                  tick
);

  localparam logic [Y_W-1:0] Y_SPAWN  = Y_W'(SPAWN_Y);
  localparam logic [Y_W-1:0] Y_LO     = Y_W'(SPAWN_Y - BOB_AMP);
  localparam logic [Y_W-1:0] Y_HI     = Y_W'(SPAWN_Y + BOB_AMP);
  localparam logic [Y_W-1:0] Y_LO_P1  = Y_W'(SPAWN_Y - BOB_AMP + 1);
  localparam logic [Y_W-1:0] Y_HI_M1  = Y_W'(SPAWN_Y + BOB_AMP - 1);
  localparam logic [X_W-1:0] X_WRAP   = X_W'(WRAP_X);

  game_state_e     st;
  logic            is_run;
  logic            is_idle;
  logic            move;
  logic [X_W+1:0]  step;

  assign st      = game_state_e'(state);
  assign is_run  = (st == ST_RUN);
  assign is_idle = (st == ST_IDLE);

  // The divider only advances in RUN and restarts whenever the game is not
  // playing; PAUSE leaves its phase untouched.
  tick_divider #(
    .DIV (DIV)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (is_run),
    .clear (is_idle || (st == ST_OVER)),
    .tick  (tick)
  );

  // A registered tick only moves sprites if the state on that edge is RUN.
  assign move = tick && is_run;

  // Step grows with speed_sel; two extra bits so the largest step never overflows.
  assign step = (X_W+2)'(STEP_X) * ((X_W+2)'(speed_sel) + (X_W+2)'(1));

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [X_W-1:0] X_SPAWN = X_W'(spawn_x(SPAWN_X, SPACING_X, WRAP_X, gi));

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           down_q, down_d;
    logic           wrap_q, wrap_d;

    // Per-channel next state: respawn in IDLE, step/wrap and bob on a move.
    always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      down_d = down_q;
      wrap_d = 1'b0;
      if (is_idle) begin
        x_d    = X_SPAWN;
        y_d    = Y_SPAWN;
        down_d = 1'b0;
      end else if (move) begin
        if ({2'b00, x_q} > step) begin
          x_d = x_q - step[X_W-1:0];
        end else begin
          x_d    = X_WRAP;
          wrap_d = 1'b1;
        end
        if (bob_en[gi]) begin
          if (!down_q) begin
            if (y_q > Y_LO)     y_d    = y_q - Y_W'(1);
            if (y_q <= Y_LO_P1) down_d = 1'b1;
          end else begin
            if (y_q < Y_HI)     y_d    = y_q + Y_W'(1);
            if (y_q >= Y_HI_M1) down_d = 1'b0;
          end
        end
      end
    end

    // Position, bob direction and wrap pulse flops.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_q    <= X_SPAWN;
        y_q    <= Y_SPAWN;
        down_q <= 1'b0;
        wrap_q <= 1'b0;
      end else begin
        x_q    <= x_d;
        y_q    <= y_d;
        down_q <= down_d;
        wrap_q <= wrap_d;
      end
    end

    assign pos_x[gi*X_W +: X_W] = x_q;
    assign pos_y[gi*Y_W +: Y_W] = y_q;
    assign wrap_pulse[gi]       = wrap_q;
  end

endmodule

// File: tb/tb_sprite_scroller.sv
// Scoreboard bench for sprite_scroller: stimulus pushes the expected result of
// every movement tick into a queue; a negedge monitor pops and compares each
// time the DUT completes a move, and checks wrap_pulse on every cycle.
module tb_sprite_scroller;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  state = ST_IDLE;
  logic [1:0]  speed_sel = 2'b00;
  logic [1:0]  bob_en = 2'b00;
  logic [19:0] pos_x;
  logic [19:0] pos_y;
  logic [1:0]  wrap_pulse;
  logic        tick;

  sprite_scroller #(
    .NUM_CH(2), .X_W(10), .Y_W(10), .DIV(4), .STEP_X(2), .SPAWN_X(800),
    .SPACING_X(320), .SPAWN_Y(260), .WRAP_X(896), .BOB_AMP(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (state),
    .speed_sel  (speed_sel),
    .bob_en     (bob_en),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .wrap_pulse (wrap_pulse),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] x;
    logic [19:0] y;
    logic [1:0]  wrap;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   mx[2];
  int   my[2];
  bit   mdn[2];
  bit   move_pend = 1'b0;

  function automatic void check(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endfunction

  // Monitor: one cycle after a tick seen in RUN the DUT presents a moved result.
  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] wexp;
    wexp = 2'b00;
    if (rst_n && move_pend) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_move: DUT moved with no expected move queued");
      end else begin
        e = exp_q.pop_front();
        check("move_x0", pos_x[9:0],   e.x[9:0]);
        check("move_x1", pos_x[19:10], e.x[19:10]);
        check("move_y0", pos_y[9:0],   e.y[9:0]);
        check("move_y1", pos_y[19:10], e.y[19:10]);
        wexp = e.wrap;
        $display("move: x=%0d/%0d y=%0d/%0d wrap=%b", pos_x[9:0], pos_x[19:10],
                 pos_y[9:0], pos_y[19:10], wrap_pulse);
      end
    end
    if (rst_n) check("wrap_pulse", wrap_pulse, wexp);
    move_pend = rst_n && (tick === 1'b1) && (state == ST_RUN);
  end

  task automatic model_spawn();
    mx[0] = 800; mx[1] = 223;
    my[0] = 260; my[1] = 260;
    mdn[0] = 1'b0; mdn[1] = 1'b0;
  endtask

  task automatic push_moves(input int n, input int spd, input logic [1:0] ben);
    exp_t e;
    int   stp;
    stp = 2 * (spd + 1);
    for (int k = 0; k < n; k++) begin
      e = '0;
      for (int ch = 0; ch < 2; ch++) begin
        if (mx[ch] > stp) mx[ch] -= stp;
        else begin mx[ch] = 896; e.wrap[ch] = 1'b1; end
        if (ben[ch]) begin
          if (!mdn[ch]) begin my[ch]--; if (my[ch] == 244) mdn[ch] = 1'b1; end
          else          begin my[ch]++; if (my[ch] == 276) mdn[ch] = 1'b0; end
        end
        e.x[ch*10 +: 10] = 10'(mx[ch]);
        e.y[ch*10 +: 10] = 10'(my[ch]);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin cyc(); c++; end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: %0d moves outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_ticks(input int n, input int spd, input logic [1:0] ben);
    speed_sel = 2'(spd);
    bob_en    = ben;
    push_moves(n, spd, ben);
    state = ST_RUN;
    wait_drain(n * 4 + 20);
    state = ST_PAUSE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_spawn();
    // 1: reset then IDLE
    cyc(); cyc();
    check("rst_x0", pos_x[9:0], 800);
    check("rst_x1", pos_x[19:10], 223);
    check("rst_y0", pos_y[9:0], 260);
    check("rst_tick", tick, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin cyc(); check("idle_tick", tick, 0); end
    check("idle_x0", pos_x[9:0], 800);
    check("idle_x1", pos_x[19:10], 223);
    check("idle_y1", pos_y[19:10], 260);

    // 2: RUN speed 0, tick on the 4th cycle, 10 ticks
    speed_sel = 2'd0;
    push_moves(10, 0, 2'b00);
    state = ST_RUN;
    for (int c = 1; c <= 4; c++) begin cyc(); check("first_tick", tick, (c == 4) ? 1 : 0); end
    wait_drain(60);
    state = ST_PAUSE;
    check("x0_after10", pos_x[9:0], 780);
    check("x1_after10", pos_x[19:10], 203);

    // 4: bob on ch0
    run_ticks(16, 0, 2'b01);
    check("bob_y0_t16", pos_y[9:0], 244);
    run_ticks(4, 0, 2'b01);
    check("bob_y0_t20", pos_y[9:0], 248);
    check("bob_y1_off", pos_y[19:10], 260);

    // 3: wrap at speed 3 from x=8, then at speed 0 from x=2
    run_ticks(2, 0, 2'b00);
    check("x0_736", pos_x[9:0], 736);
    run_ticks(91, 3, 2'b00);
    check("x0_8_a", pos_x[9:0], 8);
    run_ticks(1, 3, 2'b00);
    check("wrap_x0_s3", pos_x[9:0], 896);
    check("bob_hold_y0", pos_y[9:0], 248);
    run_ticks(111, 3, 2'b00);
    check("x0_8_b", pos_x[9:0], 8);
    run_ticks(3, 0, 2'b00);
    check("x0_2", pos_x[9:0], 2);
    run_ticks(1, 0, 2'b00);
    check("wrap_x0_s0", pos_x[9:0], 896);

    // 5: IDLE respawn, RUN 2, PAUSE 50, resume
    state = ST_IDLE;
    model_spawn();
    cyc(); cyc(); cyc();
    check("respawn_x0", pos_x[9:0], 800);
    check("respawn_y0", pos_y[9:0], 260);
    state = ST_RUN;
    cyc(); check("run2_tick", tick, 0);
    cyc(); check("run2_tick", tick, 0);
    state = ST_PAUSE;
    for (int i = 0; i < 50; i++) begin cyc(); check("pause_tick", tick, 0); end
    check("pause_x0", pos_x[9:0], 800);
    check("pause_x1", pos_x[19:10], 223);
    speed_sel = 2'd0;
    push_moves(1, 0, 2'b00);
    state = ST_RUN;
    cyc(); check("resume_tick_c1", tick, 0);
    cyc(); check("resume_tick_c2", tick, 1);
    wait_drain(20);
    state = ST_PAUSE;
    check("resume_x0", pos_x[9:0], 798);

    // 6: async reset mid-run, then OVER hold and IDLE respawn
    run_ticks(3, 0, 2'b00);
    check("pre_rst_x0", pos_x[9:0], 792);
    state = ST_RUN;
    cyc();
    rst_n = 1'b0;
    #1;
    check("async_x0", pos_x[9:0], 800);
    check("async_x1", pos_x[19:10], 223);
    check("async_tick", tick, 0);
    check("async_wrap", wrap_pulse, 0);
    rst_n = 1'b1;
    state = ST_OVER;
    model_spawn();
    run_ticks(2, 1, 2'b00);
    check("over_pre_x0", pos_x[9:0], 792);
    check("over_pre_x1", pos_x[19:10], 215);
    state = ST_OVER;
    for (int i = 0; i < 5; i++) begin cyc(); check("over_tick", tick, 0); end
    check("over_hold_x0", pos_x[9:0], 792);
    state = ST_IDLE;
    cyc();
    check("over_idle_x0", pos_x[9:0], 800);
    check("over_idle_x1", pos_x[19:10], 223);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
